// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file write-back shared constants
package rf_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  // wb_sel encodings for the result mux
  localparam logic REQ_A = 1'b1;
  localparam logic REQ_B = 1'b0;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant driven by the last winner
module rr_arb2
  import rf_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_grant_i,
  input  logic en_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // On a tie the requester that did not win last time goes next.
  assign gnt_a_o = en_i && req_a_i && (!req_b_i || (last_grant_i == REQ_B));
  assign gnt_b_o = en_i && req_b_i && (!req_a_i || (last_grant_i == REQ_A));

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write-back port between ALU (A) and load unit (B)
module wb_port_arbiter #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int CNT_W  = rf_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_sel,
  input  logic              wb_ready,
  output logic [CNT_W-1:0]  cont_cnt
);
  import rf_pkg::REQ_A;
  import rf_pkg::REQ_B;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(rf_pkg::ZERO_REG);

  logic              wb_en_q,   wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_sel_q,  wb_sel_d;
  logic              last_q,    last_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic              free;
  logic              gnt_a, gnt_b;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  assign free = !wb_en_q || wb_ready;

  // Gating with rst_n keeps both readies low while reset is held.
  rr_arb2 u_arb (
    .req_a_i      (a_valid),
    .req_b_i      (b_valid),
    .last_grant_i (last_q),
    .en_i         (free && rst_n),
    .gnt_a_o      (gnt_a),
    .gnt_b_o      (gnt_b)
  );

  assign gnt_addr = gnt_a ? a_addr : b_addr;
  assign gnt_data = gnt_a ? a_data : b_data;

  always_comb begin
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_sel_d  = wb_sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    if (free) begin
      // Writes to the zero register are accepted but never reach the file.
      wb_en_d = (gnt_a || gnt_b) && (gnt_addr != ZERO_ADDR);
      if (gnt_a || gnt_b) begin
        wb_addr_d = gnt_addr;
        wb_data_d = gnt_data;
        wb_sel_d  = gnt_a ? REQ_A : REQ_B;
        last_d    = gnt_a ? REQ_A : REQ_B;
      end
      if (a_valid && b_valid && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_sel_q  <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_sel_q  <= wb_sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_sel   = wb_sel_q;
  assign cont_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, wb_addr;
  logic [31:0] a_data, b_data, wb_data;
  logic        wb_en, wb_sel, wb_ready;
  logic [15:0] cont_cnt;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_sel(wb_sel),
    .wb_ready(wb_ready), .cont_cnt(cont_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        sel;
  } wb_t;

  wb_t sb[$];

  int checks = 0;
  int failures = 0;

  // reference state of the write-back port
  logic        m_en, m_last;
  logic [15:0] m_cnt;
  logic        obs_a, obs_b, obs_en;
  logic [4:0]  obs_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_last = 1'b0; m_cnt = '0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus (called at posedge+1), check at negedge, advance model.
  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                     input logic wr);
    logic free, ga, gb;
    wb_t  e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    wb_ready = wr;
    @(negedge clk);
    free = !m_en || wr;
    ga = free && av && (!bv || !m_last);
    gb = free && bv && (!av || m_last);
    obs_a = a_ready; obs_b = b_ready; obs_en = wb_en; obs_addr = wb_addr;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("wb_en", wb_en, m_en);
    chk("cont_cnt", cont_cnt, m_cnt);
    if (wb_en && wb_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wb_addr", wb_addr, e.addr);
        chk("wb_data", wb_data, e.data);
        chk("wb_sel", wb_sel, e.sel);
      end
    end
    if (free) begin
      m_en = 1'b0;
      if (ga) begin
        m_last = 1'b1;
        if (aa != 0) begin m_en = 1'b1; sb.push_back('{aa, ad, 1'b1}); end
      end
      if (gb) begin
        m_last = 1'b0;
        if (ba != 0) begin m_en = 1'b1; sb.push_back('{ba, bd, 1'b0}); end
      end
      if (av && bv && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        rav, rbv;
    logic [4:0]  raa, rba;
    logic [31:0] rad, rbd;
    rst_n = 1'b0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
    wb_ready = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_cont_cnt", cont_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single A request, one-cycle latency
    cyc(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 1);
    chk("t1_a_ready", obs_a, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("t1_wb_en", obs_en, 1);
    chk("t1_wb_addr", obs_addr, 3);

    // B write to register 0 is accepted and dropped
    cyc(0, 0, 0, 1, 5'd0, 32'h55, 1);
    chk("z_b_ready", obs_b, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("z_wb_en", obs_en, 0);

    // ties after B won: A, B, A, B
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(20 + i), 32'hB000_0000 + i, 1);
      chk("tie_a", obs_a, (i % 2) == 0);
      chk("tie_b", obs_b, (i % 2) == 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("tie_cnt", cont_cnt, 4);

    // stall with a pending write, then same-cycle handoff
    cyc(1, 5'd7, 32'h7777, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 5'd8, 32'h8888, 0);
      chk("stall_b_ready", obs_b, 0);
      chk("stall_addr", obs_addr, 7);
    end
    cyc(0, 0, 0, 1, 5'd8, 32'h8888, 1);
    chk("handoff_b_ready", obs_b, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("handoff_addr", obs_addr, 8);

    // bounded random traffic; requesters hold until accepted
    rav = 0; rbv = 0; raa = 0; rba = 0; rad = 0; rbd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!rav || obs_a) begin
        rav = 1'($urandom_range(0, 1)); raa = 5'($urandom_range(0, 31)); rad = $urandom;
      end
      if (!rbv || obs_b) begin
        rbv = 1'($urandom_range(0, 1)); rba = 5'($urandom_range(0, 31)); rbd = $urandom;
      end
      cyc(rav, raa, rad, rbv, rba, rbd, 1'($urandom_range(0, 3) != 0));
    end

    // saturation of the contention counter
    for (int i = 0; i < 65536 + 5; i++) begin
      cyc(1, 5'd1, i, 1, 5'd2, ~i, 1);
    end
    chk("sat_cnt", cont_cnt, 16'hFFFF);

    // asynchronous reset while a write is pending
    cyc(1, 5'd7, 32'hCAFE, 0, 0, 0, 1);
    a_valid = 1'b1; b_valid = 1'b1; wb_ready = 1'b0;
    chk("pre_rst_wb_en", wb_en, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_wb_en", wb_en, 0);
    chk("async_cnt", cont_cnt, 0);
    chk("async_a_ready", a_ready, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 5'd5, 32'h5A5A, 1, 5'd6, 32'h6B6B, 1);
    chk("post_rst_tie_a", obs_a, 1);
    cyc(0, 0, 0, 1, 5'd6, 32'h6B6B, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
